btb_update: RTL and testbench

- Write side of the 2-way, 8-set branch target buffer; counterpart of the fetch-stage lookup path.
- Accepts resolved-branch updates from execute.
- Performs a read-modify-write of the addressed set through the BTB file's update read port.
- Owns the per-set LRU state and allocation policy, and also executes a full-table invalidate (flush) walk.

---
 rtl/btb_update_pkg.sv | 32 +++
 rtl/btb_update_if.sv | 16 +
 rtl/btb_update_victim_sel.sv | 30 +++
 rtl/btb_update.sv | 178 +++++++++++++++++
 tb/tb_btb_update.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/btb_update_pkg.sv
// Shared definitions for the branch target buffer (BTB) blocks: geometry,
// the update FSM state encoding, the entry layout, and the 2-bit
// saturating counter step.
package btb_update_pkg;

  localparam int IDXW  = 3;
  localparam int TAGW  = 30 - IDXW;
  localparam int WAYS  = 2;
  localparam int NSETS = 1 << IDXW;
  localparam logic [1:0] CTR_INIT = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WRITE,
    FLUSH
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic [31:0]     target;
    logic [1:0]      ctr;
  } btb_entry;

  // Saturating 2-bit counter step: 11 holds on taken, 00 holds on not-taken.
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/btb_update_if.sv
// Resolved-branch update handshake from execute into the BTB write side.
//   valid  : update offered
//   ready  : BTB update block can accept this cycle
//   pc     : branch PC
//   target : resolved target
//   taken  : branch outcome
interface btb_update_if;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic [31:0] target;
  logic        taken;

  modport master (output valid, pc, target, taken, input ready);
  modport slave  (input valid, pc, target, taken, output ready);
endinterface

// File: rtl/btb_update_victim_sel.sv
// Way selection for an update: a hit picks the hitting way (way0 wins on a
// double hit); otherwise the first invalid way, else the LRU victim.
//   valid0/1, hit0/1 : per-way state of the addressed set
//   lru              : LRU bit of the set (way to evict when both valid)
//   way              : selected way
//   hit              : either way hit
//   alloc            : no hit, an allocation would be needed
module btb_victim_sel
  import btb_update_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic hit0,
  input  logic hit1,
  input  logic lru,
  output logic way,
  output logic hit,
  output logic alloc
);
  always_comb begin
    way = lru;
    if (hit0)        way = 1'b0;
    else if (hit1)   way = 1'b1;
    else if (!valid0) way = 1'b0;
    else if (!valid1) way = 1'b1;
  end

  assign hit   = hit0 | hit1;
  assign alloc = ~(hit0 | hit1);
endmodule

// File: rtl/btb_update.sv
// BTB write side: takes resolved-branch updates, read-modify-writes the
// addressed set through the file's update read port, owns per-set LRU, and
// walks the whole table on a flush to invalidate every way.
//   clk, rst        : clock, async active-high reset
//   upd             : update handshake (slave)
//   flush           : single-cycle request to invalidate the whole BTB
//   flush_busy      : flush walk in progress
//   ur_set_index    : read port set address; ur_* way data comes back combinationally
//   wr_*            : file write port; data holds its last value while wr_en=0
//
// state  | meaning
// IDLE   | waiting for an update handshake
// LOOKUP | file read of the set, hit/victim decision, write fields captured
// WRITE  | write strobe (if any) and LRU update
// FLUSH  | one way invalidated per cycle, cnt walks set/way
module btb_update #(
  parameter int IDXW = 3,
  parameter int TAGW = 30 - IDXW
) (
  input  logic            clk,
  input  logic            rst,
  btb_update_if.slave     upd,
  input  logic            flush,
  output logic            flush_busy,
  output logic [IDXW-1:0] ur_set_index,
  input  logic            ur_valid0,
  input  logic            ur_valid1,
  input  logic [TAGW-1:0] ur_tag0,
  input  logic [TAGW-1:0] ur_tag1,
  input  logic [1:0]      ur_ctr0,
  input  logic [1:0]      ur_ctr1,
  output logic            wr_en,
  output logic [IDXW-1:0] wr_set,
  output logic            wr_way,
  output logic            wr_valid,
  output logic [TAGW-1:0] wr_tag,
  output logic [31:0]     wr_target,
  output logic [1:0]      wr_ctr
);
  import btb_update_pkg::*;

  localparam int CNTW = IDXW + 1;
  localparam logic [CNTW-1:0] CNT_LAST = '1;

  state_t state, state_nx;
  logic [CNTW-1:0] cnt_q, cnt_nx;
  logic [31:0] pc_q, target_q;
  logic taken_q;
  logic [(1<<IDXW)-1:0] lru_q;
  logic do_write_q;

  logic [IDXW-1:0] wset_q;
  logic            wway_q, wvalid_q;
  logic [TAGW-1:0] wtag_q;
  logic [31:0]     wtarget_q;
  logic [1:0]      wctr_q;

  logic [IDXW-1:0] set_idx;
  logic [TAGW-1:0] tag_in;
  logic hit0, hit1, sel_way, sel_hit, sel_alloc, lk_write, handshake;
  logic [1:0] lk_ctr;

  assign set_idx      = pc_q[IDXW+1:2];
  assign tag_in       = pc_q[31:IDXW+2];
  assign ur_set_index = set_idx;
  assign hit0 = ur_valid0 && (ur_tag0 == tag_in);
  assign hit1 = ur_valid1 && (ur_tag1 == tag_in);

  btb_victim_sel u_victim (
    .valid0 (ur_valid0),
    .valid1 (ur_valid1),
    .hit0   (hit0),
    .hit1   (hit1),
    .lru    (lru_q[set_idx]),
    .way    (sel_way),
    .hit    (sel_hit),
    .alloc  (sel_alloc)
  );

  // Not-taken hits also rewrite the target; the counter gates its use.
  assign lk_ctr   = sel_hit ? ctr_next(sel_way ? ur_ctr1 : ur_ctr0, taken_q) : CTR_INIT;
  assign lk_write = sel_hit | (sel_alloc & taken_q);

  assign upd.ready  = (state == IDLE) && !flush;
  assign handshake  = upd.valid && upd.ready;
  assign flush_busy = (state == FLUSH);
  // A flush seen during WRITE drops the pending update, including its strobe.
  assign wr_en = ((state == WRITE) && do_write_q && !flush) || (state == FLUSH);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_q;
    unique case (state)
      IDLE:    if (handshake) state_nx = LOOKUP;
      LOOKUP:  state_nx = WRITE;
      WRITE:   state_nx = IDLE;
      FLUSH: begin
        if (cnt_q == CNT_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx = FLUSH;
      cnt_nx   = '0;
    end
  end

  always_comb begin
    wr_set    = wset_q;
    wr_way    = wway_q;
    wr_valid  = wvalid_q;
    wr_tag    = wtag_q;
    wr_target = wtarget_q;
    wr_ctr    = wctr_q;
    if (state == FLUSH) begin
      wr_set    = cnt_q[IDXW:1];
      wr_way    = cnt_q[0];
      wr_valid  = 1'b0;
      wr_tag    = '0;
      wr_target = '0;
      wr_ctr    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt_q      <= '0;
      pc_q       <= '0;
      target_q   <= '0;
      taken_q    <= 1'b0;
      lru_q      <= '0;
      do_write_q <= 1'b0;
      wset_q     <= '0;
      wway_q     <= 1'b0;
      wvalid_q   <= 1'b0;
      wtag_q     <= '0;
      wtarget_q  <= '0;
      wctr_q     <= '0;
    end else begin
      state <= state_nx;
      cnt_q <= cnt_nx;
      if (handshake) begin
        pc_q     <= upd.pc;
        target_q <= upd.target;
        taken_q  <= upd.taken;
      end
      // Write fields only move when a write will follow, so wr_* hold otherwise.
      if (state == LOOKUP && !flush) begin
        do_write_q <= lk_write;
        if (lk_write) begin
          wset_q    <= set_idx;
          wway_q    <= sel_way;
          wvalid_q  <= 1'b1;
          wtag_q    <= tag_in;
          wtarget_q <= target_q;
          wctr_q    <= lk_ctr;
        end
      end
      if (state == WRITE && do_write_q && !flush)
        lru_q[wset_q] <= ~wway_q;
      if (state == FLUSH) begin
        lru_q[cnt_q[IDXW:1]] <= 1'b0;
        wset_q    <= cnt_q[IDXW:1];
        wway_q    <= cnt_q[0];
        wvalid_q  <= 1'b0;
        wtag_q    <= '0;
        wtarget_q <= '0;
        wctr_q    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_btb_update.sv
// Directed bench for btb_update with a behavioural 2-way x 8-set BTB file
// feeding the update read port and absorbing writes.
module tb_btb_update;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic flush_busy;
  logic [2:0] ur_set_index;
  logic ur_valid0, ur_valid1;
  logic [26:0] ur_tag0, ur_tag1;
  logic [1:0] ur_ctr0, ur_ctr1;
  logic wr_en, wr_way, wr_valid;
  logic [2:0] wr_set;
  logic [26:0] wr_tag;
  logic [31:0] wr_target;
  logic [1:0] wr_ctr;

  int n_chk = 0;
  int n_fail = 0;

  btb_update_if u ();

  btb_update dut (
    .clk          (clk),
    .rst          (rst),
    .upd          (u),
    .flush        (flush),
    .flush_busy   (flush_busy),
    .ur_set_index (ur_set_index),
    .ur_valid0    (ur_valid0),
    .ur_valid1    (ur_valid1),
    .ur_tag0      (ur_tag0),
    .ur_tag1      (ur_tag1),
    .ur_ctr0      (ur_ctr0),
    .ur_ctr1      (ur_ctr1),
    .wr_en        (wr_en),
    .wr_set       (wr_set),
    .wr_way       (wr_way),
    .wr_valid     (wr_valid),
    .wr_tag       (wr_tag),
    .wr_target    (wr_target),
    .wr_ctr       (wr_ctr)
  );

  always #5 clk = ~clk;

  // Behavioural BTB file.
  logic        m_valid  [0:7][0:1];
  logic [26:0] m_tag    [0:7][0:1];
  logic [31:0] m_target [0:7][0:1];
  logic [1:0]  m_ctr    [0:7][0:1];

  assign ur_valid0 = m_valid[ur_set_index][0];
  assign ur_valid1 = m_valid[ur_set_index][1];
  assign ur_tag0   = m_tag[ur_set_index][0];
  assign ur_tag1   = m_tag[ur_set_index][1];
  assign ur_ctr0   = m_ctr[ur_set_index][0];
  assign ur_ctr1   = m_ctr[ur_set_index][1];

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 8; s++)
        for (int w = 0; w < 2; w++) begin
          m_valid[s][w]  <= 1'b0;
          m_tag[s][w]    <= '0;
          m_target[s][w] <= '0;
          m_ctr[s][w]    <= '0;
        end
    end else if (wr_en) begin
      m_valid[wr_set][wr_way]  <= wr_valid;
      m_tag[wr_set][wr_way]    <= wr_tag;
      m_target[wr_set][wr_way] <= wr_target;
      m_ctr[wr_set][wr_way]    <= wr_ctr;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One update: handshake, LOOKUP, WRITE (checked), back to IDLE.
  // With exp_en=0, e_set is the value wr_set must still hold.
  task automatic do_upd(input string t, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic tk, input logic exp_en, input logic [2:0] e_set,
                        input logic e_way, input logic [26:0] e_tag,
                        input logic [31:0] e_tgt, input logic [1:0] e_ctr);
    @(negedge clk);
    chk({t, ".rdy"}, 64'(u.ready), 64'd1);
    u.valid = 1'b1; u.pc = pc; u.target = tgt; u.taken = tk;
    @(negedge clk);
    u.valid = 1'b0;
    chk({t, ".lk_en"}, 64'(wr_en), 64'd0);
    chk({t, ".lk_rdy"}, 64'(u.ready), 64'd0);
    @(negedge clk);
    chk({t, ".en"}, 64'(wr_en), 64'(exp_en));
    if (exp_en) begin
      chk({t, ".set"}, 64'(wr_set), 64'(e_set));
      chk({t, ".way"}, 64'(wr_way), 64'(e_way));
      chk({t, ".valid"}, 64'(wr_valid), 64'd1);
      chk({t, ".tag"}, 64'(wr_tag), 64'(e_tag));
      chk({t, ".target"}, 64'(wr_target), 64'(e_tgt));
      chk({t, ".ctr"}, 64'(wr_ctr), 64'(e_ctr));
    end else begin
      chk({t, ".hold_set"}, 64'(wr_set), 64'(e_set));
    end
    @(negedge clk);
    chk({t, ".rdy_back"}, 64'(u.ready), 64'd1);
    chk({t, ".idle_en"}, 64'(wr_en), 64'd0);
  endtask

  initial begin
    int seen;
    u.valid = 1'b0; u.pc = '0; u.target = '0; u.taken = 1'b0;
    #1;
    chk("rst.wr_en", 64'(wr_en), 64'd0);
    chk("rst.busy", 64'(flush_busy), 64'd0);
    chk("rst.wr_set", 64'(wr_set), 64'd0);
    chk("rst.wr_target", 64'(wr_target), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.ready", 64'(u.ready), 64'd1);

    // Allocation into empty set 2, then counter walk on hits.
    do_upd("alloc", 32'h0000_1008, 32'h0000_2000, 1'b1, 1'b1, 3'd2, 1'b0, 27'h80, 32'h2000, 2'b10);
    chk("alloc.lru", 64'(dut.lru_q), 64'h04);
    do_upd("t1",  32'h0000_1008, 32'h0000_2000, 1'b1, 1'b1, 3'd2, 1'b0, 27'h80, 32'h2000, 2'b11);
    do_upd("t2",  32'h0000_1008, 32'h0000_2000, 1'b1, 1'b1, 3'd2, 1'b0, 27'h80, 32'h2000, 2'b11);
    do_upd("nt1", 32'h0000_1008, 32'h0000_2000, 1'b0, 1'b1, 3'd2, 1'b0, 27'h80, 32'h2000, 2'b10);
    do_upd("nt2", 32'h0000_1008, 32'h0000_2000, 1'b0, 1'b1, 3'd2, 1'b0, 27'h80, 32'h2000, 2'b01);
    do_upd("nt3", 32'h0000_1008, 32'h0000_2000, 1'b0, 1'b1, 3'd2, 1'b0, 27'h80, 32'h2000, 2'b00);
    do_upd("nt4", 32'h0000_1008, 32'h0000_2000, 1'b0, 1'b1, 3'd2, 1'b0, 27'h80, 32'h2000, 2'b00);

    // Fill way1, hit way0 (LRU[2]=1), then LRU-driven victims.
    do_upd("fill1", 32'h0000_2008, 32'h0000_2100, 1'b1, 1'b1, 3'd2, 1'b1, 27'h100, 32'h2100, 2'b10);
    chk("fill1.lru", 64'(dut.lru_q), 64'h00);
    do_upd("hit0",  32'h0000_1008, 32'h0000_2000, 1'b1, 1'b1, 3'd2, 1'b0, 27'h80, 32'h2000, 2'b01);
    do_upd("vict1", 32'h0000_3008, 32'h0000_3000, 1'b1, 1'b1, 3'd2, 1'b1, 27'h180, 32'h3000, 2'b10);
    chk("vict1.lru", 64'(dut.lru_q), 64'h00);
    do_upd("vict0", 32'h0000_4008, 32'h0000_4000, 1'b1, 1'b1, 3'd2, 1'b0, 27'h200, 32'h4000, 2'b10);
    chk("vict0.lru", 64'(dut.lru_q), 64'h04);

    // Not-taken miss on empty set 3: no write, outputs and LRU untouched.
    do_upd("ntmiss", 32'h0000_100C, 32'h0000_5000, 1'b0, 1'b0, 3'd2, 1'b0, 27'h0, 32'h0, 2'b00);
    chk("ntmiss.lru", 64'(dut.lru_q), 64'h04);
    chk("ntmiss.tgt_hold", 64'(wr_target), 64'h4000);

    // Flush during LOOKUP drops the update and walks all 16 ways.
    @(negedge clk);
    u.valid = 1'b1; u.pc = 32'h0000_1010; u.target = 32'h0000_6000; u.taken = 1'b1;
    @(negedge clk);
    u.valid = 1'b0;
    flush = 1'b1;
    chk("fl.lk_rdy", 64'(u.ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fl%0d.en", i), 64'(wr_en), 64'd1);
      chk($sformatf("fl%0d.set", i), 64'(wr_set), 64'(i >> 1));
      chk($sformatf("fl%0d.way", i), 64'(wr_way), 64'(i & 1));
      chk($sformatf("fl%0d.valid", i), 64'(wr_valid), 64'd0);
      chk($sformatf("fl%0d.zero", i), {wr_tag, wr_target, wr_ctr}, 64'd0);
      chk($sformatf("fl%0d.busy", i), 64'(flush_busy), 64'd1);
      chk($sformatf("fl%0d.rdy", i), 64'(u.ready), 64'd0);
      @(negedge clk);
    end
    chk("fl.done_busy", 64'(flush_busy), 64'd0);
    chk("fl.done_en", 64'(wr_en), 64'd0);
    chk("fl.done_rdy", 64'(u.ready), 64'd1);
    chk("fl.lru", 64'(dut.lru_q), 64'h00);
    chk("fl.set4_valid", 64'({m_valid[4][0], m_valid[4][1]}), 64'd0);

    // After flush the old entry is gone: re-allocation, not a hit.
    do_upd("realloc", 32'h0000_1008, 32'h0000_2000, 1'b1, 1'b1, 3'd2, 1'b0, 27'h80, 32'h2000, 2'b10);

    // Reset in the middle of a flush walk at cnt=5.
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (5) @(negedge clk);
    chk("rf.cnt5_set", 64'(wr_set), 64'd2);
    chk("rf.cnt5_way", 64'(wr_way), 64'd1);
    rst = 1'b1;
    #1;
    chk("rf.en", 64'(wr_en), 64'd0);
    chk("rf.busy", 64'(flush_busy), 64'd0);
    chk("rf.set", 64'(wr_set), 64'd0);
    chk("rf.rdy", 64'(u.ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (wr_en) seen++;
    end
    chk("rf.no_wr_after", 64'(seen), 64'd0);
    chk("rf.idle_busy", 64'(flush_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
